l2_req_scheduler: RTL and testbench

Three-way request scheduler sitting between the L1 instruction cache, L1 data cache, an optional next-line prefetcher, and the single 256-bit L2 port. Sequences exactly one outstanding L2 transaction at a time using fixed priority with anti-starvation aging for instruction fetch. Latches the winner's address and data, routes the L2 response back to the winner only, then returns to idle.

---
 rtl/l2_req_scheduler.sv | 162 ++++++++++++++++
 tb/tb_l2_req_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_scheduler.sv
// Single-outstanding L2 request scheduler: dcache > icache > prefetch, with icache aging.
// Define L2_SCHED_PREFETCH_EN to let the prefetch port take part in arbitration.
module l2_req_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [31:0]  dcache_address,
    input  logic [255:0] dcache_wdata,
    output logic [255:0] dcache_rdata,
    output logic         dcache_resp,
    input  logic         icache_read,
    input  logic [31:0]  icache_address,
    output logic [255:0] icache_rdata,
    output logic         icache_resp,
    input  logic         pf_read,
    input  logic [31:0]  pf_address,
    output logic [255:0] pf_rdata,
    output logic         pf_resp,
    output logic         l2_read,
    output logic         l2_write,
    output logic [31:0]  l2_address,
    output logic [255:0] l2_wdata,
    input  logic [255:0] l2_rdata,
    input  logic         l2_resp,
    output logic [1:0]   grant_id
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned OFS_W  = 5;
    localparam int unsigned AGE_W  = 4;
    localparam int unsigned GID_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        BUSY_P = 2'd3
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic                r_l2_read,  w_l2_read_nxt;
    logic                r_l2_write, w_l2_write_nxt;
    logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
    logic [LINE_W-1:0]   r_wdata,    w_wdata_nxt;
    logic [GID_W-1:0]    r_grant,    w_grant_nxt;
    logic [AGE_W-1:0]    r_age,      w_age_nxt;

    logic w_d_req;
    logic w_pf_req;
    logic w_i_starved;

    assign w_d_req     = dcache_read | dcache_write;
    assign w_i_starved = icache_read && (r_age == AGE_W'(STARVE_LIMIT));

`ifdef L2_SCHED_PREFETCH_EN
    assign w_pf_req = pf_read;
    assign pf_resp  = (r_state == BUSY_P) && l2_resp;
    assign pf_rdata = l2_rdata;

    logic w_unused_bits;
    assign w_unused_bits = ^{dcache_address[OFS_W-1:0], icache_address[OFS_W-1:0],
                             pf_address[OFS_W-1:0]};
`else
    assign w_pf_req = 1'b0;
    assign pf_resp  = 1'b0;
    assign pf_rdata = '0;

    logic w_unused_bits;
    assign w_unused_bits = ^{pf_read, dcache_address[OFS_W-1:0], icache_address[OFS_W-1:0],
                             pf_address[OFS_W-1:0]};
`endif

    // State and latched command registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_grant    <= '0;
            r_age      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_l2_read  <= w_l2_read_nxt;
            r_l2_write <= w_l2_write_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_grant    <= w_grant_nxt;
            r_age      <= w_age_nxt;
        end
    end

    // Arbitration in IDLE, completion on l2_resp in any BUSY state
    always_comb begin
        w_state_nxt    = r_state;
        w_l2_read_nxt  = r_l2_read;
        w_l2_write_nxt = r_l2_write;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_grant_nxt    = r_grant;
        w_age_nxt      = r_age;

        case (r_state)
            IDLE: begin
                if (!icache_read) begin
                    w_age_nxt = '0;
                end
                if (w_i_starved || (!w_d_req && icache_read)) begin
                    w_state_nxt    = BUSY_I;
                    w_l2_read_nxt  = 1'b1;
                    w_l2_write_nxt = 1'b0;
                    w_addr_nxt     = {icache_address[ADDR_W-1:OFS_W], OFS_W'(0)};
                    w_grant_nxt    = GID_W'(2);
                    w_age_nxt      = '0;
                end else if (w_d_req) begin
                    // A simultaneous read+write is serviced as the writeback
                    w_state_nxt    = BUSY_D;
                    w_l2_read_nxt  = !dcache_write;
                    w_l2_write_nxt = dcache_write;
                    w_addr_nxt     = {dcache_address[ADDR_W-1:OFS_W], OFS_W'(0)};
                    w_grant_nxt    = GID_W'(1);
                    if (dcache_write) begin
                        w_wdata_nxt = dcache_wdata;
                    end
                    if (icache_read && (r_age != {AGE_W{1'b1}})) begin
                        w_age_nxt = r_age + AGE_W'(1);
                    end
                end else if (w_pf_req) begin
                    w_state_nxt    = BUSY_P;
                    w_l2_read_nxt  = 1'b1;
                    w_l2_write_nxt = 1'b0;
                    w_addr_nxt     = {pf_address[ADDR_W-1:OFS_W], OFS_W'(0)};
                    w_grant_nxt    = GID_W'(3);
                end
            end
            default: begin
                if (l2_resp) begin
                    w_state_nxt    = IDLE;
                    w_l2_read_nxt  = 1'b0;
                    w_l2_write_nxt = 1'b0;
                    w_grant_nxt    = '0;
                end
            end
        endcase
    end

    assign l2_read      = r_l2_read;
    assign l2_write     = r_l2_write;
    assign l2_address   = r_addr;
    assign l2_wdata     = r_wdata;
    assign grant_id     = r_grant;

    assign dcache_resp  = (r_state == BUSY_D) && l2_resp;
    assign icache_resp  = (r_state == BUSY_I) && l2_resp;
    assign dcache_rdata = l2_rdata;
    assign icache_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_req_scheduler.sv
// Self-checking bench for l2_req_scheduler: vector table, directed corner cases, random traffic vs model.
module tb_l2_req_scheduler;
    localparam int unsigned LIMIT = 4;
`ifdef L2_SCHED_PREFETCH_EN
    localparam logic PF_EN = 1'b1;
`else
    localparam logic PF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         dcache_read, dcache_write;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         pf_read;
    logic [31:0]  pf_address;
    logic [255:0] pf_rdata;
    logic         pf_resp;
    logic         l2_read, l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;
    logic [1:0]   grant_id;

    l2_req_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .pf_read(pf_read), .pf_address(pf_address),
        .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .l2_read(l2_read), .l2_write(l2_write),
        .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int age      = 0;

    typedef struct {
        logic        d_rd, d_wr, i_rd, p_rd;
        logic [31:0] d_addr, i_addr, p_addr;
        logic [1:0]  e_gid;
        logic        e_rd, e_wr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[9];

    localparam logic [255:0] WD_A5 = {32{8'hA5}};

    function automatic vec_t mk(input logic d_rd, input logic d_wr, input logic i_rd,
                                input logic p_rd, input logic [31:0] d_addr,
                                input logic [31:0] i_addr, input logic [31:0] p_addr,
                                input logic [1:0] gid, input logic rd, input logic wr,
                                input logic [31:0] addr);
        vec_t v;
        v.d_rd = d_rd; v.d_wr = d_wr; v.i_rd = i_rd; v.p_rd = p_rd;
        v.d_addr = d_addr; v.i_addr = i_addr; v.p_addr = p_addr;
        v.e_gid = gid; v.e_rd = rd; v.e_wr = wr; v.e_addr = addr;
        return v;
    endfunction

    // Reference arbitration: aged icache first, then fixed priority
    function automatic int pick(input logic d, input logic i, input logic p, input int a);
        if (i && a == int'(LIMIT)) return 2;
        if (d) return 1;
        if (i) return 2;
        if (p && PF_EN) return 3;
        return 0;
    endfunction

    function automatic logic [2:0] onehot(input int g);
        if (g == 0) return 3'b000;
        return 3'(1 << (g - 1));
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic d_rd, input logic d_wr, input logic i_rd, input logic p_rd,
                         input logic [31:0] d_addr, input logic [31:0] i_addr,
                         input logic [31:0] p_addr, input logic [255:0] wd);
        dcache_read = d_rd; dcache_write = d_wr; icache_read = i_rd; pf_read = p_rd;
        dcache_address = d_addr; icache_address = i_addr; pf_address = p_addr;
        dcache_wdata = wd;
    endtask

    function automatic logic [2:0] resps();
        return {pf_resp, icache_resp, dcache_resp};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_seq[10];
        logic rd_d, rd_w, rd_i, rd_p;
        logic [31:0] ad, ai, ap;
        logic [255:0] wd, rv;
        int eg, lat;
        exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

        vecs[0] = mk(1,0,0,0, 32'h1234_5678, 0, 0, 2'd1, 1, 0, 32'h1234_5660);
        vecs[1] = mk(0,1,0,0, 32'h0000_1234, 0, 0, 2'd1, 0, 1, 32'h0000_1220);
        vecs[2] = mk(1,1,0,0, 32'hFFFF_FFFF, 0, 0, 2'd1, 0, 1, 32'hFFFF_FFE0);
        vecs[3] = mk(0,0,1,0, 0, 32'h8000_021F, 0, 2'd2, 1, 0, 32'h8000_0200);
        vecs[4] = mk(1,0,1,0, 32'h40, 32'h80, 0, 2'd1, 1, 0, 32'h40);
        vecs[5] = mk(0,0,0,1, 0, 0, 32'h0000_0105, PF_EN ? 2'd3 : 2'd0, PF_EN, 0, 32'h100);
        vecs[6] = mk(0,0,1,1, 0, 32'h0000_0A00, 32'h0000_0B00, 2'd2, 1, 0, 32'h0000_0A00);
        vecs[7] = mk(0,0,0,0, 32'h1000, 32'h2000, 32'h3000, 2'd0, 0, 0, 0);
        vecs[8] = mk(0,1,1,1, 32'h0000_C03F, 32'h1, 32'h2, 2'd1, 0, 1, 32'h0000_C020);

        // Reset with every request asserted
        reset_n = 1'b0;
        l2_resp = 1'b1;
        l2_rdata = '0;
        drive(1, 0, 1, 1, 32'h0000_5555, 32'h0000_6666, 32'h0000_7777, '0);
        tick(); tick();
        chk("rst_l2_read", 256'(l2_read), 0);
        chk("rst_l2_write", 256'(l2_write), 0);
        chk("rst_l2_address", 256'(l2_address), 0);
        chk("rst_l2_wdata", l2_wdata, 0);
        chk("rst_grant_id", 256'(grant_id), 0);
        chk("rst_resps", 256'(resps()), 0);
        l2_resp = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("rel_l2_read", 256'(l2_read), 1);
        chk("rel_grant_id", 256'(grant_id), 1);
        chk("rel_l2_address", 256'(l2_address), 256'(32'h0000_5540));
        l2_resp = 1'b1;
        #1 chk("rel_resps", 256'(resps()), 256'(3'b001));
        tick();
        l2_resp = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Table-driven single transactions
        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].d_rd, vecs[k].d_wr, vecs[k].i_rd, vecs[k].p_rd,
                  vecs[k].d_addr, vecs[k].i_addr, vecs[k].p_addr, WD_A5);
            tick();
            chk($sformatf("v%0d_gid", k), 256'(grant_id), 256'(vecs[k].e_gid));
            chk($sformatf("v%0d_rd", k), 256'(l2_read), 256'(vecs[k].e_rd));
            chk($sformatf("v%0d_wr", k), 256'(l2_write), 256'(vecs[k].e_wr));
            if (vecs[k].e_gid != 2'd0) begin
                chk($sformatf("v%0d_addr", k), 256'(l2_address), 256'(vecs[k].e_addr));
                if (vecs[k].e_wr) chk($sformatf("v%0d_wdata", k), l2_wdata, WD_A5);
                rv = {8{$urandom}};
                l2_rdata = rv;
                l2_resp = 1'b1;
                #1;
                chk($sformatf("v%0d_resp", k), 256'(resps()), 256'(onehot(int'(vecs[k].e_gid))));
                chk($sformatf("v%0d_drdata", k), dcache_rdata, rv);
                chk($sformatf("v%0d_irdata", k), icache_rdata, rv);
                chk($sformatf("v%0d_prdata", k), pf_rdata, PF_EN ? rv : 256'(0));
                tick();
                l2_resp = 1'b0;
                drive(0, 0, 0, 0, 0, 0, 0, '0);
                #1;
                chk($sformatf("v%0d_gid_clr", k), 256'(grant_id), 0);
                chk($sformatf("v%0d_rd_clr", k), 256'(l2_read | l2_write), 0);
            end
            drive(0, 0, 0, 0, 0, 0, 0, '0);
            tick();
        end

        // dcache writeback with five-cycle L2 latency
        drive(0, 1, 0, 0, 32'h0000_1234, 0, 0, WD_A5);
        tick();
        for (int c = 0; c < 4; c++) begin
            dcache_wdata = '0;
            dcache_address = 32'hDEAD_BEEF;
            #1;
            chk("wb_hold_addr", 256'(l2_address), 256'(32'h0000_1220));
            chk("wb_hold_wdata", l2_wdata, WD_A5);
            chk("wb_hold_cmd", 256'({l2_read, l2_write}), 256'(2'b01));
            chk("wb_no_resp", 256'(resps()), 0);
            tick();
        end
        l2_resp = 1'b1;
        #1 chk("wb_resp", 256'(resps()), 256'(3'b001));
        tick();
        l2_resp = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        #1 chk("wb_resp_pulse", 256'(resps()), 0);
        tick();

        // Continuous dcache+icache pressure exercises aging
        drive(1, 0, 1, 0, 32'h0000_0400, 32'h0000_0800, 0, '0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("age_grant%0d", k), 256'(grant_id), 256'(exp_seq[k]));
            l2_resp = 1'b1;
            tick();
            l2_resp = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Prefetch behind icache
        drive(0, 0, 1, 1, 0, 32'h0000_0200, 32'h0000_0100, '0);
        tick();
        chk("pf_first_gid", 256'(grant_id), 2);
        chk("pf_first_addr", 256'(l2_address), 256'(32'h200));
        l2_resp = 1'b1;
        #1 chk("pf_first_resp", 256'(resps()), 256'(3'b010));
        tick();
        l2_resp = 1'b0;
        icache_read = 1'b0;
        tick();
        chk("pf_second_gid", 256'(grant_id), PF_EN ? 256'(3) : 256'(0));
        chk("pf_second_rd", 256'(l2_read), 256'(PF_EN));
        l2_resp = 1'b1;
        #1 chk("pf_second_resp", 256'(resps()), PF_EN ? 256'(3'b100) : 256'(0));
        tick();
        l2_resp = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Reset pulse during BUSY_I
        drive(0, 0, 1, 0, 0, 32'h0000_0300, 0, '0);
        tick();
        chk("ri_gid", 256'(grant_id), 2);
        tick();
        reset_n = 1'b0;
        #1;
        chk("ri_rd_async", 256'(l2_read), 0);
        chk("ri_gid_async", 256'(grant_id), 0);
        l2_resp = 1'b1;
        #1 chk("ri_no_resp", 256'(resps()), 0);
        tick();
        reset_n = 1'b1;
        l2_resp = 1'b0;
        tick();
        chk("ri_regrant_gid", 256'(grant_id), 2);
        chk("ri_regrant_addr", 256'(l2_address), 256'(32'h300));
        l2_resp = 1'b1;
        #1 chk("ri_regrant_resp", 256'(resps()), 256'(3'b010));
        tick();
        l2_resp = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Spurious l2_resp while idle
        l2_resp = 1'b1;
        #1 chk("sp_no_resp", 256'(resps()), 0);
        tick();
        l2_resp = 1'b0;
        chk("sp_gid", 256'(grant_id), 0);
        chk("sp_cmd", 256'({l2_read, l2_write}), 0);
        drive(0, 1, 0, 0, 32'h0000_0060, 0, 0, WD_A5);
        tick();
        chk("sp_after_gid", 256'(grant_id), 1);
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        tick();

        // Random traffic against the reference model
        age = 0;
        for (int t = 0; t < 60; t++) begin
            rd_d = ($urandom_range(0, 3) != 0);
            rd_w = rd_d & $urandom_range(0, 1);
            rd_i = $urandom_range(0, 1);
            rd_p = $urandom_range(0, 1);
            ad = $urandom; ai = $urandom; ap = $urandom; wd = {8{$urandom}};
            drive(rd_d & !rd_w, rd_w, rd_i, rd_p, ad, ai, ap, wd);
            eg = pick(rd_d, rd_i, rd_p, age);
            if (eg == 2 || !rd_i) age = 0;
            else if (eg == 1 && age < 15) age++;
            tick();
            chk($sformatf("rnd%0d_gid", t), 256'(grant_id), 256'(eg));
            if (eg == 0) begin
                chk($sformatf("rnd%0d_idle", t), 256'({l2_read, l2_write}), 0);
            end else begin
                chk($sformatf("rnd%0d_addr", t), 256'(l2_address),
                    256'((eg == 1) ? {ad[31:5], 5'b0} : (eg == 2) ? {ai[31:5], 5'b0} : {ap[31:5], 5'b0}));
                chk($sformatf("rnd%0d_cmd", t), 256'({l2_read, l2_write}),
                    256'((eg == 1 && rd_w) ? 2'b01 : 2'b10));
                if (eg == 1 && rd_w) chk($sformatf("rnd%0d_wdata", t), l2_wdata, wd);
                lat = $urandom_range(0, 3);
                for (int c = 0; c < lat; c++) begin
                    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom, $urandom, $urandom, '0);
                    #1;
                    chk($sformatf("rnd%0d_wait", t), 256'({resps(), grant_id}), 256'({3'b000, 2'(eg)}));
                    tick();
                end
                rv = {8{$urandom}};
                l2_rdata = rv;
                l2_resp = 1'b1;
                #1;
                chk($sformatf("rnd%0d_resp", t), 256'(resps()), 256'(onehot(eg)));
                chk($sformatf("rnd%0d_rdata", t), dcache_rdata, rv);
                tick();
                l2_resp = 1'b0;
                #1 chk($sformatf("rnd%0d_clr", t), 256'(grant_id), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
